// File: rtl/serial_half_duplex_ctrl.sv
// Round-robin scheduler sharing one half-duplex UART between two requesters.
// Optional echo self-check of transmitted bytes: define SERIAL_CTRL_ECHO_CHECK_EN.
module serial_half_duplex_ctrl #(
  parameter int unsigned CLK_FREQ_HZ       = 27_000_000,
  parameter int unsigned TURNAROUND_CYCLES = 64,
  parameter int unsigned RX_TIMEOUT_CYCLES = 27_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_req_tx_len,
  input  logic [15:0] i_req_rx_len,
  output logic [1:0]  o_grant,
  input  logic [15:0] i_src_data,
  input  logic [1:0]  i_src_valid,
  output logic [1:0]  o_src_ready,
  output logic [7:0]  o_rsp_data,
  output logic [1:0]  o_rsp_valid,
  output logic [1:0]  o_xfer_done,
  output logic        o_xfer_timeout,
  output logic        o_echo_err,
  output logic [7:0]  o_uart_tx_data,
  output logic        o_uart_tx_valid,
  input  logic        i_uart_tx_ready,
  input  logic [7:0]  i_uart_rx_data,
  input  logic        i_uart_rx_valid,
  output logic        o_uart_half_duplex_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_TX_LOAD, S_TX_WAIT, S_TURN, S_RX, S_DONE
  } state_t;

  localparam logic [23:0] TURN_LAST  = 24'(TURNAROUND_CYCLES - 1);
  localparam logic [23:0] RX_TO_LAST = 24'(RX_TIMEOUT_CYCLES - 1);

  generate
    if (CLK_FREQ_HZ == 0 || TURNAROUND_CYCLES == 0 || RX_TIMEOUT_CYCLES == 0 ||
        RX_TIMEOUT_CYCLES > 24'hFF_FFFF) begin : g_bad_param
      $error("serial_half_duplex_ctrl: timing parameters out of range");
    end
  endgenerate

  state_t      r_state, w_next;
  logic        r_owner, r_last_owner;
  logic [1:0]  r_grant;
  logic [7:0]  r_tx_len, r_rx_len, r_tx_cnt, r_rx_cnt;
  logic [23:0] r_timer;
  logic        r_first, r_timeout;
  logic [1:0]  r_src_ready, r_rsp_valid;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data, r_rsp_data;

  logic        w_pick, w_src_vld, w_tx_fire, w_rx_take, w_to_hit;
  logic [7:0]  w_src_byte, w_pick_tx_len, w_pick_rx_len;

  // With both requesting, the one that did not win last time gets the line.
  assign w_pick        = (i_req == 2'b11) ? ~r_last_owner : i_req[1];
  assign w_pick_tx_len = w_pick ? i_req_tx_len[15:8] : i_req_tx_len[7:0];
  assign w_pick_rx_len = w_pick ? i_req_rx_len[15:8] : i_req_rx_len[7:0];
  assign w_src_byte    = r_owner ? i_src_data[15:8] : i_src_data[7:0];
  assign w_src_vld     = i_src_valid[r_owner];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_fire = 1'b0;
    w_rx_take = 1'b0;
    w_to_hit  = 1'b0;
    case (r_state)
      S_IDLE:    if (|i_req) w_next = S_GRANT;
      S_GRANT: begin
        if (r_tx_len != 8'd0)      w_next = S_TX_LOAD;
        else if (r_rx_len != 8'd0) w_next = S_TURN;
        else                       w_next = S_DONE;
      end
      S_TX_LOAD: begin
        if (w_src_vld && i_uart_tx_ready) begin
          w_tx_fire = 1'b1;
          w_next    = S_TX_WAIT;
        end
      end
      // tx_ready is stale in the first cycle: the UART has not yet left idle.
      S_TX_WAIT: begin
        if (!r_first && i_uart_tx_ready) begin
          if (r_tx_cnt < r_tx_len)   w_next = S_TX_LOAD;
          else if (r_rx_len != 8'd0) w_next = S_TURN;
          else                       w_next = S_DONE;
        end
      end
      S_TURN:    if (r_timer == TURN_LAST) w_next = S_RX;
      S_RX: begin
        if (i_uart_rx_valid) begin
          w_rx_take = 1'b1;
          if (r_rx_cnt + 8'd1 == r_rx_len) w_next = S_DONE;
        end else if (r_timer == RX_TO_LAST) begin
          w_to_hit = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_grant      <= '0;
      r_tx_len     <= '0;
      r_rx_len     <= '0;
      r_tx_cnt     <= '0;
      r_rx_cnt     <= '0;
      r_first      <= 1'b0;
      r_timeout    <= 1'b0;
      r_src_ready  <= '0;
      r_rsp_valid  <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_src_ready <= '0;
      r_rsp_valid <= '0;
      r_tx_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_grant      <= w_pick ? 2'b10 : 2'b01;
            r_tx_len     <= w_pick_tx_len;
            r_rx_len     <= w_pick_rx_len;
            r_tx_cnt     <= '0;
            r_rx_cnt     <= '0;
            r_timeout    <= 1'b0;
          end
        end
        S_TX_LOAD: begin
          if (w_tx_fire) begin
            r_tx_data   <= w_src_byte;
            r_tx_valid  <= 1'b1;
            r_src_ready <= r_grant;
            r_tx_cnt    <= r_tx_cnt + 8'd1;
            r_first     <= 1'b1;
          end
        end
        S_TX_WAIT: r_first <= 1'b0;
        S_RX: begin
          if (w_rx_take) begin
            r_rsp_data  <= i_uart_rx_data;
            r_rsp_valid <= r_grant;
            r_rx_cnt    <= r_rx_cnt + 8'd1;
          end
          if (w_to_hit) r_timeout <= 1'b1;
        end
        S_DONE:  r_grant <= '0;
        default: ;
      endcase
    end
  end

  // One timer serves both the turnaround gap and the per-byte reply timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        S_TURN:  r_timer <= (r_timer == TURN_LAST) ? 24'd0 : r_timer + 24'd1;
        S_RX:    r_timer <= w_rx_take ? 24'd0 : r_timer + 24'd1;
        default: r_timer <= '0;
      endcase
    end
  end

`ifdef SERIAL_CTRL_ECHO_CHECK_EN
  logic r_echo_seen, r_echo_err;

  // The line is looped back while driven, so each sent byte should echo before tx_ready returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo_seen <= 1'b0;
      r_echo_err  <= 1'b0;
    end else begin
      if (r_state == S_GRANT) r_echo_err <= 1'b0;
      if (w_tx_fire)          r_echo_seen <= 1'b0;
      if (r_state == S_TX_WAIT) begin
        if (i_uart_rx_valid) begin
          r_echo_seen <= 1'b1;
          if (i_uart_rx_data != r_tx_data) r_echo_err <= 1'b1;
        end
        if (!r_first && i_uart_tx_ready && !r_echo_seen && !i_uart_rx_valid)
          r_echo_err <= 1'b1;
      end
    end
  end

  assign o_echo_err = (r_state == S_DONE) && r_echo_err;
`else
  assign o_echo_err = 1'b0;
`endif

  assign o_grant               = r_grant;
  assign o_src_ready           = r_src_ready;
  assign o_rsp_data            = r_rsp_data;
  assign o_rsp_valid           = r_rsp_valid;
  assign o_xfer_done           = (r_state == S_DONE) ? r_grant : 2'b00;
  assign o_xfer_timeout        = (r_state == S_DONE) && r_timeout;
  assign o_uart_tx_data        = r_tx_data;
  assign o_uart_tx_valid       = r_tx_valid;
  assign o_uart_half_duplex_en = (r_state == S_GRANT) || (r_state == S_TX_LOAD) ||
                                 (r_state == S_TX_WAIT);

endmodule

// File: tb/tb_serial_half_duplex_ctrl.sv
// Directed bench for serial_half_duplex_ctrl: behavioural UART/loopback, two byte sources, vector table.
`timescale 1ns/1ps
module tb_serial_half_duplex_ctrl;

`ifdef SERIAL_CTRL_ECHO_CHECK_EN
  localparam bit ECHO_ON = 1'b1;
`else
  localparam bit ECHO_ON = 1'b0;
`endif
  localparam int RX_TO = 27_000;

  logic        clk, rst_n;
  logic [1:0]  req;
  logic [15:0] req_tx_len, req_rx_len;
  logic [1:0]  grant;
  logic [15:0] src_data;
  logic [1:0]  src_valid, src_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_valid, xfer_done;
  logic        xfer_timeout, echo_err;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, hde;

  serial_half_duplex_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_tx_len(req_tx_len),
    .i_req_rx_len(req_rx_len), .o_grant(grant), .i_src_data(src_data),
    .i_src_valid(src_valid), .o_src_ready(src_ready), .o_rsp_data(rsp_data),
    .o_rsp_valid(rsp_valid), .o_xfer_done(xfer_done), .o_xfer_timeout(xfer_timeout),
    .o_echo_err(echo_err), .o_uart_tx_data(uart_tx_data), .o_uart_tx_valid(uart_tx_valid),
    .i_uart_tx_ready(uart_tx_ready), .i_uart_rx_data(uart_rx_data),
    .i_uart_rx_valid(uart_rx_valid), .o_uart_half_duplex_en(hde)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct packed {
    logic [1:0]  req;
    logic [7:0]  tx_len;
    logic [31:0] txb;
    logic [7:0]  rx_len;
    logic [7:0]  nrep;
    logic [23:0] rep;
    logic        echo_bad;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_ntx;
    logic [7:0]  exp_nrsp;
    logic        exp_to;
    logic [15:0] exp_hde;
  } vec_t;

  // Stimulus configuration, written by the main sequence only.
  logic [31:0] cur_s0, cur_s1;
  int          cur_l0, cur_l1, cur_rx, cur_nrep, vec_id;
  logic [23:0] cur_rep;
  logic        cur_echo_bad;

  // Environment observations, written by the environment process only.
  logic [7:0]  tx_log [0:1023];
  logic [7:0]  rsp_log[0:1023];
  int n_tx, n_rsp, n_hde, n_srdy0, n_srdy1, n_bad, done_cnt, done_cyc, last_rsp_cyc, last_gap;
  logic [1:0] done_grant;
  logic       done_to, done_echo;

  int n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // UART + loopback + source model. UART busy 7 cycles per byte after accepting tx_valid.
  initial begin : env
    int cyc, t0, busy, idx0, idx1, seen_id, zero_run;
    bit pend, prev_hde;
    logic [7:0] last_tx;
    cyc = 0; t0 = -1; busy = 0; idx0 = 0; idx1 = 0; seen_id = 0; zero_run = 0;
    pend = 0; prev_hde = 0; last_tx = 8'h00;
    n_tx = 0; n_rsp = 0; n_hde = 0; n_srdy0 = 0; n_srdy1 = 0; n_bad = 0; done_cnt = 0;
    done_cyc = 0; last_rsp_cyc = 0; last_gap = 0; done_grant = 0; done_to = 0; done_echo = 0;
    uart_tx_ready = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    src_valid = 2'b00; src_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      cyc++;
      uart_rx_valid = 1'b0;
      if (vec_id != seen_id) begin seen_id = vec_id; idx0 = 0; idx1 = 0; t0 = -1; end
      if (!rst_n) begin
        pend = 0; busy = 0; uart_tx_ready = 1'b1; prev_hde = 0;
      end else begin
        if (src_ready[0]) begin n_srdy0++; idx0++; end
        if (src_ready[1]) begin n_srdy1++; idx1++; end
        if ((src_ready & ~grant) != 2'b00) n_bad++;
        if (rsp_valid != 2'b00) begin
          rsp_log[n_rsp] = rsp_data; n_rsp++; last_rsp_cyc = cyc;
          if (rsp_valid != grant) n_bad++;
        end
        if (hde) n_hde++;
        if (prev_hde && !hde && cur_rx > 0) t0 = cyc;
        prev_hde = hde;
        if (grant == 2'b00) zero_run++;
        else if (zero_run > 0) begin last_gap = zero_run; zero_run = 0; end
        if (xfer_done != 2'b00) begin
          done_cnt++; done_grant = xfer_done; done_to = xfer_timeout;
          done_echo = echo_err; done_cyc = cyc;
        end
        if (pend) begin pend = 0; uart_tx_ready = 1'b0; busy = 6; end
        else if (busy > 0) begin
          busy--;
          if (busy == 3) begin uart_rx_valid = 1'b1; uart_rx_data = cur_echo_bad ? 8'hFF : last_tx; end
          if (busy == 0) uart_tx_ready = 1'b1;
        end
        if (uart_tx_valid) begin
          pend = 1; last_tx = uart_tx_data; tx_log[n_tx] = uart_tx_data; n_tx++;
        end
        // Stray byte on the last TURN cycle must be dropped; replies start on the first RX cycle.
        if (t0 >= 0 && cyc == t0 + 63) begin uart_rx_valid = 1'b1; uart_rx_data = 8'hEE; end
        for (int k = 0; k < cur_nrep; k++)
          if (t0 >= 0 && cyc == t0 + 64 + 3 * k) begin
            uart_rx_valid = 1'b1; uart_rx_data = cur_rep[8*k +: 8];
          end
      end
      src_valid[0]  = (idx0 < cur_l0);
      src_valid[1]  = (idx1 < cur_l1);
      src_data[7:0]  = (idx0 < 4) ? cur_s0[8*idx0 +: 8] : 8'h00;
      src_data[15:8] = (idx1 < 4) ? cur_s1[8*idx1 +: 8] : 8'h00;
    end
  end

  task automatic wait_done(input string name, input bit drop_req);
    int base;
    base = done_cnt;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (drop_req && grant != 2'b00) req = 2'b00;
      if (done_cnt != base) break;
    end
    chk({name, " done seen"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int btx, brsp, bhde, bs0, bs1;
    logic o;
    string nm;
    nm = $sformatf("v%0d", id);
    btx = n_tx; brsp = n_rsp; bhde = n_hde; bs0 = n_srdy0; bs1 = n_srdy1;
    o = v.req[1];
    if (!o) begin cur_s0 = v.txb; cur_l0 = int'(v.tx_len); cur_s1 = 32'h0000ADDE; cur_l1 = 2; end
    else    begin cur_s1 = v.txb; cur_l1 = int'(v.tx_len); cur_s0 = 32'h0000ADDE; cur_l0 = 2; end
    cur_rx = int'(v.rx_len); cur_nrep = int'(v.nrep); cur_rep = v.rep; cur_echo_bad = v.echo_bad;
    vec_id++;
    @(negedge clk);
    req        = v.req;
    req_tx_len = o ? {v.tx_len, 8'h07} : {8'h07, v.tx_len};
    req_rx_len = o ? {v.rx_len, 8'h07} : {8'h07, v.rx_len};
    wait_done(nm, 1'b1);
    repeat (4) @(negedge clk);
    chk({nm, " done owner"}, {30'd0, done_grant}, {30'd0, v.exp_grant});
    chk({nm, " tx count"}, 32'(n_tx - btx), {24'd0, v.exp_ntx});
    for (int k = 0; k < int'(v.exp_ntx) && k < 4; k++)
      chk($sformatf("%s tx byte%0d", nm, k), {24'd0, tx_log[btx + k]}, {24'd0, v.txb[8*k +: 8]});
    chk({nm, " rsp count"}, 32'(n_rsp - brsp), {24'd0, v.exp_nrsp});
    for (int k = 0; k < int'(v.exp_nrsp) && k < 3; k++)
      chk($sformatf("%s rsp byte%0d", nm, k), {24'd0, rsp_log[brsp + k]}, {24'd0, v.rep[8*k +: 8]});
    chk({nm, " timeout"}, {31'd0, done_to}, {31'd0, v.exp_to});
    chk({nm, " echo_err"}, {31'd0, done_echo}, {31'd0, ECHO_ON & v.echo_bad});
    chk({nm, " hde cycles"}, 32'(n_hde - bhde), {16'd0, v.exp_hde});
    chk({nm, " src_ready owner"}, 32'(o ? n_srdy1 - bs1 : n_srdy0 - bs0), {24'd0, v.exp_ntx});
    chk({nm, " src_ready other"}, 32'(o ? n_srdy0 - bs0 : n_srdy1 - bs1), 32'd0);
    chk({nm, " grant released"}, {30'd0, grant}, 32'd0);
    if (v.exp_to && v.exp_nrsp != 8'd0)
      chk({nm, " timeout gap"}, 32'(done_cyc - last_rsp_cyc), 32'(RX_TO));
  endtask

  vec_t vecs[7];

  initial begin : main
    logic [1:0] g[3];
    int btx;
    n_vec = 0; n_err = 0;
    vecs[0] = '{2'b01, 8'd3, 32'h00015AA5, 8'd2, 8'd2, 24'h002211, 1'b0, 2'b01, 8'd3, 8'd2, 1'b0, 16'd28};
    vecs[1] = '{2'b10, 8'd2, 32'h00003CC3, 8'd1, 8'd1, 24'h000077, 1'b0, 2'b10, 8'd2, 8'd1, 1'b0, 16'd19};
    vecs[2] = '{2'b01, 8'd0, 32'h00000000, 8'd1, 8'd1, 24'h000099, 1'b0, 2'b01, 8'd0, 8'd1, 1'b0, 16'd1};
    vecs[3] = '{2'b10, 8'd1, 32'h00000081, 8'd0, 8'd0, 24'h000000, 1'b0, 2'b10, 8'd1, 8'd0, 1'b0, 16'd10};
    vecs[4] = '{2'b01, 8'd0, 32'h00000000, 8'd0, 8'd0, 24'h000000, 1'b0, 2'b01, 8'd0, 8'd0, 1'b0, 16'd1};
    vecs[5] = '{2'b10, 8'd1, 32'h000000A5, 8'd0, 8'd0, 24'h000000, 1'b1, 2'b10, 8'd1, 8'd0, 1'b0, 16'd10};
    vecs[6] = '{2'b01, 8'd2, 32'h00003412, 8'd2, 8'd1, 24'h000055, 1'b0, 2'b01, 8'd2, 8'd1, 1'b1, 16'd19};

    cur_s0 = 0; cur_s1 = 0; cur_l0 = 0; cur_l1 = 0; cur_rx = 0; cur_nrep = 0;
    cur_rep = 0; cur_echo_bad = 0; vec_id = 0;
    rst_n = 1'b0; req = 2'b00; req_tx_len = 16'h0; req_rx_len = 16'h0;

    repeat (3) @(negedge clk);
    chk("reset grant/done", {28'd0, grant, xfer_done}, 32'd0);
    chk("reset tx/hde", {22'd0, uart_tx_data, uart_tx_valid, hde}, 32'd0);
    chk("reset rsp", {22'd0, rsp_data, rsp_valid}, 32'd0);
    chk("reset flags", {28'd0, src_ready, xfer_timeout, echo_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both requesting from reset and held: owners alternate starting with requester 0.
    cur_s0 = 32'h0000B1B0; cur_l0 = 2; cur_s1 = 32'h0000C1C0; cur_l1 = 2; vec_id++;
    btx = n_tx;
    @(negedge clk);
    req = 2'b11; req_tx_len = 16'h0101; req_rx_len = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      wait_done($sformatf("arb%0d", i), 1'b0);
      g[i] = done_grant;
    end
    req = 2'b00;
    chk("arb grant0", {30'd0, g[0]}, 32'd1);
    chk("arb grant1", {30'd0, g[1]}, 32'd2);
    chk("arb grant2", {30'd0, g[2]}, 32'd1);
    chk("arb idle gap", 32'(last_gap), 32'd1);
    chk("arb tx byte0", {24'd0, tx_log[btx]},     32'hB0);
    chk("arb tx byte1", {24'd0, tx_log[btx + 1]}, 32'hC0);
    chk("arb tx byte2", {24'd0, tx_log[btx + 2]}, 32'hB1);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset asserted while a byte is on the wire.
    cur_s0 = 32'h00332211; cur_l0 = 3; cur_s1 = 0; cur_l1 = 0; cur_rx = 0; cur_nrep = 0;
    cur_echo_bad = 0; vec_id++;
    btx = n_tx;
    @(negedge clk);
    req = 2'b01; req_tx_len = 16'h0003; req_rx_len = 16'h0000;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (grant != 2'b00) req = 2'b00;
      if (n_tx != btx) break;
    end
    chk("rst tx started", 32'(n_tx - btx), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst grant/done", {28'd0, grant, xfer_done}, 32'd0);
    chk("rst hde/tx_valid", {30'd0, hde, uart_tx_valid}, 32'd0);
    chk("rst tx_data", {24'd0, uart_tx_data}, 32'd0);
    chk("rst src_ready/rsp", {28'd0, src_ready, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(7, vecs[3]);

    chk("owner-only strobes", 32'(n_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
